// File: rtl/projection_seg.sv
// Frame projection segmenter: builds column/row foreground histograms over one frame,
// then sweeps them to find up to MAX_SEG padded border pairs per axis.
module projection_seg #(
  parameter int unsigned H_PIXEL = 1280,
  parameter int unsigned V_PIXEL = 720,
  parameter int unsigned MAX_SEG = 8,
  parameter int unsigned CNT_W   = 11,
  parameter int unsigned MARGIN  = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              frame_vsync,
  input  logic                              frame_de,
  input  logic                              monoc,
  input  logic [10:0]                       xpos,
  input  logic [10:0]                       ypos,
  input  logic [CNT_W-1:0]                  thresh_h,
  input  logic [CNT_W-1:0]                  thresh_v,
  input  logic [7:0]                        min_width,
  input  logic [$clog2(2*MAX_SEG)-1:0]      col_rd_addr,
  output logic [10:0]                       col_rd_data,
  input  logic [$clog2(2*MAX_SEG)-1:0]      row_rd_addr,
  output logic [10:0]                       row_rd_data,
  output logic [3:0]                        num_col,
  output logic [3:0]                        num_row,
  output logic                              done,
  output logic                              overflow
);

  localparam int unsigned CA_W = $clog2(H_PIXEL);
  localparam int unsigned RA_W = $clog2(V_PIXEL);
  localparam int unsigned SC_W = $clog2(MAX_SEG + 1);
  localparam logic [CA_W-1:0]  H_LAST  = CA_W'(H_PIXEL - 1);
  localparam logic [CA_W-1:0]  V_CNT   = CA_W'(V_PIXEL);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {CLEAR, WAIT, ACCUM, SCAN, PUBLISH} state_t;

  state_t state, state_nx;

  logic              vs_q, de_q;
  logic [10:0]       y_q;
  logic [CA_W-1:0]   clr_cnt;
  logic [CNT_W-1:0]  col_bin [H_PIXEL];
  logic [CNT_W-1:0]  row_bin [V_PIXEL];
  logic [CNT_W-1:0]  col_rq, row_rq;
  logic              s1_v, fwd;
  logic [CA_W-1:0]   s1_addr;
  logic [CNT_W-1:0]  wr_val, row_acc;

  logic              vs_fall, de_fall, inc, scan_start, publish;
  logic [CNT_W-1:0]  col_base, col_new, col_wd, row_wd;
  logic              col_we, row_we;
  logic [CA_W-1:0]   col_wa, col_ra;
  logic [RA_W-1:0]   row_wa, row_ra;

  logic [10:0]       col_addr, row_addr;
  logic              col_fin, row_fin, col_ovf, row_ovf;
  logic [SC_W-1:0]   col_cnt, row_cnt;

  assign vs_fall    = vs_q && !frame_vsync;
  assign de_fall    = de_q && !frame_de;
  assign inc        = (state == ACCUM) && frame_de && !monoc;
  assign scan_start = (state == ACCUM) && vs_fall;
  assign publish    = (state == SCAN) && col_fin && row_fin;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= CLEAR;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      CLEAR:   if (clr_cnt == H_LAST)  state_nx = WAIT;
      WAIT:    if (vs_fall)            state_nx = ACCUM;
      ACCUM:   if (vs_fall)            state_nx = SCAN;
      SCAN:    if (col_fin && row_fin) state_nx = PUBLISH;
      PUBLISH:                         state_nx = CLEAR;
      default:                         state_nx = CLEAR;
    endcase
  end

  // Bin port muxing; a repeat of the same column forwards the value just written
  always_comb begin
    col_base = fwd ? wr_val : col_rq;
    col_new  = (col_base == CNT_MAX) ? col_base : col_base + CNT_W'(1);
    col_ra   = (state == SCAN) ? CA_W'(col_addr) : CA_W'(xpos);
    col_we   = 1'b0;
    col_wa   = s1_addr;
    col_wd   = col_new;
    if (state == CLEAR) begin
      col_we = 1'b1;
      col_wa = clr_cnt;
      col_wd = '0;
    end else if (s1_v) begin
      col_we = 1'b1;
    end
    row_ra = RA_W'(row_addr);
    row_we = 1'b0;
    row_wa = RA_W'(y_q);
    row_wd = row_acc;
    if (state == CLEAR) begin
      row_we = (clr_cnt < V_CNT);
      row_wa = RA_W'(clr_cnt);
      row_wd = '0;
    end else if ((state == ACCUM) && de_fall) begin
      row_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (col_we) col_bin[col_wa] <= col_wd;
    col_rq <= col_bin[col_ra];
  end

  always_ff @(posedge clk) begin
    if (row_we) row_bin[row_wa] <= row_wd;
    row_rq <= row_bin[row_ra];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
      y_q     <= '0;
      clr_cnt <= '0;
      s1_v    <= 1'b0;
      s1_addr <= '0;
      fwd     <= 1'b0;
      wr_val  <= '0;
      row_acc <= '0;
    end else begin
      vs_q    <= frame_vsync;
      de_q    <= frame_de;
      if (frame_de) y_q <= ypos;
      clr_cnt <= ((state == CLEAR) && (clr_cnt != H_LAST)) ? clr_cnt + CA_W'(1) : '0;
      s1_v    <= inc;
      s1_addr <= CA_W'(xpos);
      fwd     <= inc && s1_v && (s1_addr == CA_W'(xpos));
      wr_val  <= col_new;
      if ((state != ACCUM) || de_fall)         row_acc <= '0;
      else if (inc && (row_acc != CNT_MAX))    row_acc <= row_acc + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_col  <= '0;
      num_row  <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= publish;
      if (publish) begin
        num_col <= 4'(col_cnt);
        num_row <= 4'(row_cnt);
      end
      if (state == PUBLISH)   overflow <= 1'b0;
      else if (state == SCAN) overflow <= col_ovf || row_ovf;
    end
  end

  projection_seg_axis #(
    .N(H_PIXEL), .MAX_SEG(MAX_SEG), .CNT_W(CNT_W), .MARGIN(MARGIN)
  ) u_col (
    .clk(clk), .rst_n(rst_n), .start(scan_start), .publish(publish),
    .bin(col_rq), .thresh(thresh_h), .min_width(min_width),
    .rd_addr(col_rd_addr), .addr(col_addr), .fin(col_fin), .ovf(col_ovf),
    .cnt(col_cnt), .rd_data(col_rd_data)
  );

  projection_seg_axis #(
    .N(V_PIXEL), .MAX_SEG(MAX_SEG), .CNT_W(CNT_W), .MARGIN(MARGIN)
  ) u_row (
    .clk(clk), .rst_n(rst_n), .start(scan_start), .publish(publish),
    .bin(row_rq), .thresh(thresh_v), .min_width(min_width),
    .rd_addr(row_rd_addr), .addr(row_addr), .fin(row_fin), .ovf(row_ovf),
    .cnt(row_cnt), .rd_data(row_rd_data)
  );

endmodule

// One axis sweep: binarises the histogram stream, tracks runs and stores padded borders.
module projection_seg_axis #(
  parameter int unsigned N       = 1280,
  parameter int unsigned MAX_SEG = 8,
  parameter int unsigned CNT_W   = 11,
  parameter int unsigned MARGIN  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          publish,
  input  logic [CNT_W-1:0]              bin,
  input  logic [CNT_W-1:0]              thresh,
  input  logic [7:0]                    min_width,
  input  logic [$clog2(2*MAX_SEG)-1:0]  rd_addr,
  output logic [10:0]                   addr,
  output logic                          fin,
  output logic                          ovf,
  output logic [$clog2(MAX_SEG+1)-1:0]  cnt,
  output logic [10:0]                   rd_data
);

  localparam int unsigned POS_W = 11;
  localparam int unsigned AW    = $clog2(2*MAX_SEG);
  localparam int unsigned SC_W  = $clog2(MAX_SEG + 1);
  localparam logic [POS_W-1:0] LAST = POS_W'(N - 1);
  localparam logic [POS_W-1:0] MG   = POS_W'(MARGIN);
  localparam logic [SC_W-1:0]  CMAX = SC_W'(MAX_SEG);

  logic              running, a_v, in_seg;
  logic [POS_W-1:0]  a_q, seg_start, mw_q;
  logic [CNT_W-1:0]  th_q;
  logic              hit, close, commit, wr_en;
  logic [POS_W-1:0]  c_start, c_end, seg_len, lo, hi;
  logic [POS_W:0]    hi_sum;
  logic [AW-1:0]     wa;
  logic [POS_W-1:0]  work [2*MAX_SEG];
  logic [POS_W-1:0]  pub  [2*MAX_SEG];

  // a_q is the address whose bin arrives this cycle
  always_comb begin
    hit     = a_v && (bin >= th_q);
    close   = 1'b0;
    c_start = seg_start;
    c_end   = a_q;
    if (a_v) begin
      if (hit && (a_q == LAST)) begin
        close = 1'b1;
        if (!in_seg) c_start = a_q;
      end else if (!hit && in_seg) begin
        close = 1'b1;
        c_end = a_q - POS_W'(1);
      end
    end
    seg_len = c_end - c_start + POS_W'(1);
    commit  = close && (seg_len >= mw_q);
    wr_en   = commit && (cnt != CMAX);
    lo      = (c_start >= MG) ? c_start - MG : '0;
    hi_sum  = {1'b0, c_end} + {1'b0, MG};
    hi      = (hi_sum > {1'b0, LAST}) ? LAST : hi_sum[POS_W-1:0];
    wa      = AW'({cnt, 1'b0});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      running   <= 1'b0;
      a_v       <= 1'b0;
      a_q       <= '0;
      addr      <= '0;
      in_seg    <= 1'b0;
      seg_start <= '0;
      fin       <= 1'b0;
      ovf       <= 1'b0;
      cnt       <= '0;
      th_q      <= '0;
      mw_q      <= '0;
      rd_data   <= '0;
    end else begin
      rd_data <= pub[rd_addr];
      if (start) begin
        running <= 1'b1;
        a_v     <= 1'b0;
        addr    <= '0;
        in_seg  <= 1'b0;
        fin     <= 1'b0;
        ovf     <= 1'b0;
        cnt     <= '0;
        th_q    <= thresh;
        mw_q    <= (min_width == 8'd0) ? POS_W'(1) : POS_W'(min_width);
      end else begin
        a_v <= running;
        a_q <= addr;
        if (running) begin
          if (addr == LAST) running <= 1'b0;
          else              addr    <= addr + POS_W'(1);
        end
        if (a_v) begin
          if (a_q == LAST) begin
            fin    <= 1'b1;
            in_seg <= 1'b0;
          end else if (hit && !in_seg) begin
            in_seg    <= 1'b1;
            seg_start <= a_q;
          end else if (!hit) begin
            in_seg <= 1'b0;
          end
        end
        if (commit) begin
          if (cnt == CMAX) ovf <= 1'b1;
          else             cnt <= cnt + SC_W'(1);
        end
      end
    end
  end

  // Working borders fill during the sweep; readers see only the published copy
  always_ff @(posedge clk) begin
    if (wr_en) begin
      work[wa]                  <= lo;
      work[{wa[AW-1:1], 1'b1}]  <= hi;
    end
    if (publish) pub <= work;
  end

endmodule

// File: tb/tb_projection_seg.sv
// Directed bench for projection_seg: sparse foreground frames with hand-derived borders.
module tb_projection_seg;

  localparam int unsigned CNT_W = 11;

  logic        clk;
  logic        rst_n;
  logic        frame_vsync, frame_de, monoc;
  logic [10:0] xpos, ypos;
  logic [CNT_W-1:0] thresh_h, thresh_v;
  logic [7:0]  min_width;
  logic [3:0]  col_rd_addr, row_rd_addr;
  logic [10:0] col_rd_data, row_rd_data;
  logic [3:0]  num_col, num_row;
  logic        done, overflow;

  int total;
  int bad;
  int eb [16];

  projection_seg #(
    .H_PIXEL(1280), .V_PIXEL(720), .MAX_SEG(8), .CNT_W(CNT_W), .MARGIN(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_vsync(frame_vsync), .frame_de(frame_de),
    .monoc(monoc), .xpos(xpos), .ypos(ypos), .thresh_h(thresh_h),
    .thresh_v(thresh_v), .min_width(min_width), .col_rd_addr(col_rd_addr),
    .col_rd_data(col_rd_data), .row_rd_addr(row_rd_addr),
    .row_rd_data(row_rd_data), .num_col(num_col), .num_row(num_row),
    .done(done), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_vsync();
    frame_vsync = 1'b1;
    tick();
    tick();
    frame_vsync = 1'b0;
    tick();
    tick();
  endtask

  // Foreground block, each pixel repeated reps times; de drops after every row
  task automatic draw_rect(input int x0, input int x1, input int y0, input int y1,
                           input int reps);
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        for (int r = 0; r < reps; r++) begin
          frame_de = 1'b1;
          monoc    = 1'b0;
          xpos     = 11'(x);
          ypos     = 11'(y);
          tick();
        end
      end
      frame_de = 1'b0;
      monoc    = 1'b1;
      tick();
    end
  endtask

  // Enter SCAN, wait for done, check single pulse and overflow, let CLEAR finish
  task automatic finish_frame(input int th_h, input int th_v, input int mw,
                              input int exp_ovf, input string tag);
    int  n_done;
    int  ovf_at;
    bit  seen;
    thresh_h  = CNT_W'(th_h);
    thresh_v  = CNT_W'(th_v);
    min_width = 8'(mw);
    tick();
    tick();
    pulse_vsync();
    n_done = 0;
    ovf_at = 0;
    seen   = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen   = 1'b1;
        n_done++;
        ovf_at = int'(overflow);
      end
    end
    repeat (1400) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check_val({tag, " done pulses"}, n_done, 1);
    check_val({tag, " overflow"}, ovf_at, exp_ovf);
  endtask

  task automatic check_counts(input string tag, input int nc, input int nr);
    check_val({tag, " num_col"}, int'(num_col), nc);
    check_val({tag, " num_row"}, int'(num_row), nr);
  endtask

  task automatic set_eb(input int a0, input int a1, input int a2, input int a3,
                        input int a4, input int a5);
    eb[0] = a0; eb[1] = a1; eb[2] = a2; eb[3] = a3; eb[4] = a4; eb[5] = a5;
  endtask

  task automatic check_borders(input bit is_row, input string tag, input int n);
    int v;
    for (int i = 0; i < n; i++) begin
      if (is_row) row_rd_addr = 4'(i);
      else        col_rd_addr = 4'(i);
      @(posedge clk);
      #1;
      v = is_row ? int'(row_rd_data) : int'(col_rd_data);
      check_val($sformatf("%s[%0d]", tag, i), v, eb[i]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check_val({tag, " num_col"}, int'(num_col), 0);
    check_val({tag, " num_row"}, int'(num_row), 0);
    check_val({tag, " done"}, int'(done), 0);
    check_val({tag, " overflow"}, int'(overflow), 0);
  endtask

  initial begin
    int n_done;
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    frame_vsync = 1'b0;
    frame_de    = 1'b0;
    monoc       = 1'b1;
    xpos        = '0;
    ypos        = '0;
    thresh_h    = CNT_W'(1);
    thresh_v    = CNT_W'(1);
    min_width   = 8'd1;
    col_rd_addr = '0;
    row_rd_addr = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (1300) tick();

    // Three rectangles over rows 200-299
    pulse_vsync();
    draw_rect(100, 149, 200, 299, 1);
    draw_rect(400, 459, 200, 299, 1);
    draw_rect(900, 979, 200, 299, 1);
    finish_frame(1, 1, 1, 0, "rects");
    check_counts("rects", 3, 1);
    set_eb(98, 151, 398, 461, 898, 981);
    check_borders(1'b0, "rects col", 6);
    set_eb(198, 301, 0, 0, 0, 0);
    check_borders(1'b1, "rects row", 2);

    // Stripes touching both image edges
    pulse_vsync();
    draw_rect(0, 9, 10, 11, 1);
    draw_rect(1270, 1279, 10, 11, 1);
    finish_frame(1, 1, 1, 0, "edges");
    check_counts("edges", 2, 1);
    set_eb(0, 11, 1268, 1279, 0, 0);
    check_borders(1'b0, "edges col", 4);
    set_eb(8, 13, 0, 0, 0, 0);
    check_borders(1'b1, "edges row", 2);

    // 3-wide stripe rejected by min_width 4; 10-row run kept
    pulse_vsync();
    draw_rect(50, 52, 10, 19, 1);
    finish_frame(1, 1, 4, 0, "narrow");
    check_counts("narrow", 0, 1);
    set_eb(8, 21, 0, 0, 0, 0);
    check_borders(1'b1, "narrow row", 2);

    // Ten 2-wide stripes with min_width 2: first eight stored, overflow set
    pulse_vsync();
    for (int i = 0; i < 10; i++) draw_rect(100*i + 10, 100*i + 11, 5, 6, 1);
    finish_frame(1, 1, 2, 1, "ovf");
    check_counts("ovf", 8, 1);
    for (int i = 0; i < 8; i++) begin
      eb[2*i]     = 100*i + 8;
      eb[2*i + 1] = 100*i + 13;
    end
    check_borders(1'b0, "ovf col", 16);
    set_eb(3, 8, 0, 0, 0, 0);
    check_borders(1'b1, "ovf row", 2);

    // Column 5 hit 3x per row on all 720 rows saturates at 2047; min_width 0 acts as 1
    pulse_vsync();
    draw_rect(5, 5, 0, 719, 3);
    finish_frame(2047, 1, 0, 0, "sat");
    check_counts("sat", 1, 1);
    set_eb(3, 7, 0, 0, 0, 0);
    check_borders(1'b0, "sat col", 2);
    set_eb(0, 719, 0, 0, 0, 0);
    check_borders(1'b1, "sat row", 2);

    // Threshold 2: single pixel at x=6 below, two pixels at x=20 exactly at it
    pulse_vsync();
    draw_rect(6, 6, 0, 0, 1);
    draw_rect(20, 20, 0, 1, 1);
    finish_frame(2, 1, 1, 0, "thr");
    check_counts("thr", 1, 1);
    set_eb(18, 22, 0, 0, 0, 0);
    check_borders(1'b0, "thr col", 2);
    set_eb(0, 3, 0, 0, 0, 0);
    check_borders(1'b1, "thr row", 2);

    // Reset in the middle of SCAN abandons the frame
    pulse_vsync();
    draw_rect(30, 39, 40, 49, 1);
    thresh_h  = CNT_W'(1);
    thresh_v  = CNT_W'(1);
    min_width = 8'd1;
    tick();
    pulse_vsync();
    repeat (100) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    check_reset_outputs("midscan reset");
    rst_n = 1'b1;
    n_done = 0;
    repeat (1400) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check_val("midscan no done", n_done, 0);
    pulse_vsync();
    draw_rect(30, 39, 40, 49, 1);
    finish_frame(1, 1, 1, 0, "after reset");
    check_counts("after reset", 1, 1);
    set_eb(28, 41, 0, 0, 0, 0);
    check_borders(1'b0, "after reset col", 2);
    set_eb(38, 51, 0, 0, 0, 0);
    check_borders(1'b1, "after reset row", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
